// File: rtl/kernel_run_sequencer.sv
// Batch sequencer for an ap_ctrl_hs-style kernel: gates N_IN input and N_OUT output beats per run.
// Optional stall watchdog with BLOCKED state is enabled by defining SEQ_WATCHDOG_EN.
module kernel_run_sequencer #(
  parameter int DATA_W  = 32,
  parameter int N_IN    = 16,
  parameter int N_OUT   = 4,
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 1024
) (
  input  logic              kernel_monitor_clock,
  input  logic              kernel_monitor_reset,
  input  logic              cmd_start,
  input  logic [CNT_W-1:0]  cmd_runs,
  input  logic              cmd_clear,
  input  logic [DATA_W-1:0] src_TDATA,
  input  logic              src_TVALID,
  output logic              src_TREADY,
  output logic [DATA_W-1:0] in_r_TDATA,
  output logic              in_r_TVALID,
  input  logic              in_r_TREADY,
  input  logic [DATA_W-1:0] out_r_TDATA,
  input  logic              out_r_TVALID,
  output logic              out_r_TREADY,
  output logic [DATA_W-1:0] snk_TDATA,
  output logic              snk_TVALID,
  input  logic              snk_TREADY,
  output logic              ap_start,
  input  logic              ap_ready,
  input  logic              ap_done,
  input  logic              ap_idle,
  output logic              busy,
  output logic              done,
  output logic              block_err,
  output logic [CNT_W-1:0]  runs_done
);

  localparam int IN_W  = $clog2(N_IN + 1);
  localparam int OUT_W = $clog2(N_OUT + 1);
  localparam logic [IN_W-1:0]  IN_MAX  = IN_W'(N_IN);
  localparam logic [OUT_W-1:0] OUT_MAX = OUT_W'(N_OUT);

  // The watchdog limit must be representable in the CNT_W counter.
  if (TIMEOUT < 1 || (TIMEOUT >> CNT_W) != 0) begin : g_timeout_range
    $error("TIMEOUT must fit in CNT_W bits and be nonzero");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_STREAM,
    S_WAIT_DONE,
    S_FINISH
`ifdef SEQ_WATCHDOG_EN
    , S_BLOCKED
`endif
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  runs_lat_q, runs_lat_d;
  logic [CNT_W-1:0]  runs_done_q, runs_done_d;
  logic [IN_W-1:0]   in_cnt_q, in_cnt_d;
  logic [OUT_W-1:0]  out_cnt_q, out_cnt_d;
  logic              done_cap_q, done_cap_d;
  logic              done_q, done_d;

  logic              in_open, out_open;
  logic              in_beat, out_beat;
  logic              run_end;
  logic [CNT_W:0]    runs_next;
  logic              last_run;
  logic              unused_ap_idle;

  assign unused_ap_idle = ap_idle;

  assign in_open  = (state_q == S_STREAM) && (in_cnt_q < IN_MAX);
  assign out_open = ((state_q == S_STREAM) || (state_q == S_WAIT_DONE)) && (out_cnt_q < OUT_MAX);

  assign in_r_TVALID  = in_open & src_TVALID;
  assign src_TREADY   = in_open & in_r_TREADY;
  assign snk_TVALID   = out_open & out_r_TVALID;
  assign out_r_TREADY = out_open & snk_TREADY;
  assign in_r_TDATA   = src_TDATA;
  assign snk_TDATA    = out_r_TDATA;

  assign in_beat  = in_open & src_TVALID & in_r_TREADY;
  assign out_beat = out_open & out_r_TVALID & snk_TREADY;

  assign ap_start  = (state_q == S_START);
  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign runs_done = runs_done_q;

  // Widened by one bit so a full-scale batch length cannot wrap the compare.
  assign runs_next = {1'b0, runs_done_q} + 1'b1;
  assign last_run  = (runs_next >= {1'b0, runs_lat_q});

`ifdef SEQ_WATCHDOG_EN
  localparam logic [CNT_W-1:0] WD_LIMIT = CNT_W'(TIMEOUT);
  logic [CNT_W-1:0] wd_q, wd_d;
  logic             block_err_q, block_err_d;
  assign block_err = block_err_q;
`else
  assign block_err = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    runs_lat_d  = runs_lat_q;
    runs_done_d = runs_done_q;
    in_cnt_d    = in_cnt_q;
    out_cnt_d   = out_cnt_q;
    done_cap_d  = done_cap_q;
    done_d      = done_q;
    run_end     = 1'b0;

    if (in_beat)  in_cnt_d  = in_cnt_q + 1'b1;
    if (out_beat) out_cnt_d = out_cnt_q + 1'b1;

    if (cmd_clear)             done_d = 1'b0;
    if (state_q == S_FINISH)   done_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (cmd_start && (cmd_runs != '0)) begin
          runs_lat_d  = cmd_runs;
          runs_done_d = '0;
          done_cap_d  = 1'b0;
          state_d     = S_START;
        end
      end
      S_START: begin
        if (ap_done) done_cap_d = 1'b1;
        if (ap_ready) begin
          state_d   = S_STREAM;
          in_cnt_d  = '0;
          out_cnt_d = '0;
        end
      end
      S_STREAM: begin
        if ((in_cnt_q == IN_MAX) && (out_cnt_q == OUT_MAX)) begin
          if (done_cap_q || ap_done) run_end = 1'b1;
          else                       state_d = S_WAIT_DONE;
        end else if (ap_done) begin
          done_cap_d = 1'b1;
        end
      end
      S_WAIT_DONE: begin
        if (done_cap_q || ap_done) run_end = 1'b1;
      end
      S_FINISH: state_d = S_IDLE;
`ifdef SEQ_WATCHDOG_EN
      S_BLOCKED: begin
        if (cmd_clear) state_d = S_IDLE;
      end
`endif
      default: state_d = S_IDLE;
    endcase

    if (run_end) begin
      runs_done_d = runs_next[CNT_W-1:0];
      done_cap_d  = 1'b0;
      state_d     = last_run ? S_FINISH : S_START;
    end

`ifdef SEQ_WATCHDOG_EN
    wd_d        = '0;
    block_err_d = block_err_q;
    if (cmd_clear) block_err_d = 1'b0;
    // A stall overrides any transition decided above.
    if ((state_q == S_STREAM) || (state_q == S_WAIT_DONE)) begin
      if (!(in_beat || out_beat || ap_done)) begin
        wd_d = wd_q + 1'b1;
        if (wd_d == WD_LIMIT) begin
          state_d     = S_BLOCKED;
          block_err_d = 1'b1;
          wd_d        = '0;
        end
      end
    end
`endif
  end

  always_ff @(posedge kernel_monitor_clock or posedge kernel_monitor_reset) begin
    if (kernel_monitor_reset) begin
      state_q     <= S_IDLE;
      runs_lat_q  <= '0;
      runs_done_q <= '0;
      in_cnt_q    <= '0;
      out_cnt_q   <= '0;
      done_cap_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      runs_lat_q  <= runs_lat_d;
      runs_done_q <= runs_done_d;
      in_cnt_q    <= in_cnt_d;
      out_cnt_q   <= out_cnt_d;
      done_cap_q  <= done_cap_d;
      done_q      <= done_d;
    end
  end

`ifdef SEQ_WATCHDOG_EN
  always_ff @(posedge kernel_monitor_clock or posedge kernel_monitor_reset) begin
    if (kernel_monitor_reset) begin
      wd_q        <= '0;
      block_err_q <= 1'b0;
    end else begin
      wd_q        <= wd_d;
      block_err_q <= block_err_d;
    end
  end
`endif

endmodule

// File: tb/tb_kernel_run_sequencer.sv
// Directed bench for kernel_run_sequencer: emulated source/kernel/sink plus a run-level model
// checked every cycle; watchdog scenario runs when SEQ_WATCHDOG_EN is defined.
module tb_kernel_run_sequencer;
  localparam int DATA_W = 32, N_IN = 16, N_OUT = 4, CNT_W = 16, TIMEOUT = 1024;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              cmd_start = 1'b0, cmd_clear = 1'b0;
  logic [CNT_W-1:0]  cmd_runs = '0;
  logic [DATA_W-1:0] src_TDATA = '0, in_r_TDATA, out_r_TDATA = '0, snk_TDATA;
  logic              src_TVALID = 1'b0, src_TREADY, in_r_TVALID, in_r_TREADY = 1'b0;
  logic              out_r_TVALID = 1'b0, out_r_TREADY, snk_TVALID, snk_TREADY = 1'b0;
  logic              ap_start, ap_ready = 1'b0, ap_done = 1'b0, ap_idle = 1'b1;
  logic              busy, done, block_err;
  logic [CNT_W-1:0]  runs_done;

  kernel_run_sequencer #(.DATA_W(DATA_W), .N_IN(N_IN), .N_OUT(N_OUT), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .kernel_monitor_clock(clk), .kernel_monitor_reset(rst),
    .cmd_start(cmd_start), .cmd_runs(cmd_runs), .cmd_clear(cmd_clear),
    .src_TDATA(src_TDATA), .src_TVALID(src_TVALID), .src_TREADY(src_TREADY),
    .in_r_TDATA(in_r_TDATA), .in_r_TVALID(in_r_TVALID), .in_r_TREADY(in_r_TREADY),
    .out_r_TDATA(out_r_TDATA), .out_r_TVALID(out_r_TVALID), .out_r_TREADY(out_r_TREADY),
    .snk_TDATA(snk_TDATA), .snk_TVALID(snk_TVALID), .snk_TREADY(snk_TREADY),
    .ap_start(ap_start), .ap_ready(ap_ready), .ap_done(ap_done), .ap_idle(ap_idle),
    .busy(busy), .done(done), .block_err(block_err), .runs_done(runs_done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Environment knobs (written by the stimulus, read by the emulators)
  int  src_total = 0;
  int  snk_limit = 1 << 30;
  int  k_done_at = 4;
  bit  thr = 1'b0;
  bit  k_en = 1'b1;

  // Environment observations
  int  src_idx = 0, snk_cnt = 0, start_pulses = 0;
  int  k_out = 0, k_data = 0, start_age = 0;
  bit  k_active = 1'b0, done_sent = 1'b0, ap_start_prev = 1'b0;
  bit  hs_src, hs_kout, hs_snk;

  // Source / kernel / sink emulation: handshakes sampled at negedge, new values driven after posedge.
  initial begin
    forever begin
      @(negedge clk);
      hs_src  = src_TVALID && src_TREADY;
      hs_kout = out_r_TVALID && out_r_TREADY;
      hs_snk  = snk_TVALID && snk_TREADY;
      @(posedge clk);
      #1;
      if (ap_start && !ap_start_prev) start_pulses++;
      ap_start_prev = ap_start;
      if (rst) begin
        k_active = 1'b0; done_sent = 1'b0; start_age = 0;
        ap_ready = 1'b0; ap_done = 1'b0;
      end else begin
        if (hs_src) src_idx++;
        if (hs_snk) snk_cnt++;
        if (hs_kout) begin k_out++; k_data++; end
        start_age = ap_start ? start_age + 1 : 0;
        ap_ready  = (start_age == 2);
        if (ap_ready) begin k_active = 1'b1; k_out = 0; done_sent = 1'b0; end
        ap_done = 1'b0;
        if (k_active && !done_sent && k_out >= k_done_at) begin ap_done = 1'b1; done_sent = 1'b1; end
      end
      ap_idle      = !k_active;
      src_TVALID   = (src_idx < src_total) && (!thr || ($urandom_range(0, 1) == 1));
      src_TDATA    = 32'hA000_0000 + src_idx;
      in_r_TREADY  = k_en && (!thr || ($urandom_range(0, 1) == 1));
      out_r_TVALID = k_en && k_active && (k_out < N_OUT) && (!thr || ($urandom_range(0, 1) == 1));
      out_r_TDATA  = 32'hC000_0000 + k_data;
      snk_TREADY   = (snk_cnt < snk_limit) && (!thr || ($urandom_range(0, 1) == 1));
    end
  end

  // Run-level reference model and per-cycle compare
  typedef enum int {P_IDLE, P_START, P_STREAM, P_WAIT, P_FIN, P_BLOCKED} phase_t;
  phase_t m_ph = P_IDLE;
  int     m_ib = 0, m_ob = 0, m_runs = 0, m_tgt = 0, m_wd = 0;
  bit     m_dcap = 1'b0, m_done = 1'b0, m_berr = 1'b0;
  bit     in_open, out_open, in_hs, out_hs, was_stream, run_end;

  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        m_ph = P_IDLE; m_ib = 0; m_ob = 0; m_runs = 0; m_tgt = 0; m_wd = 0;
        m_dcap = 1'b0; m_done = 1'b0; m_berr = 1'b0;
      end
      in_open  = (m_ph == P_STREAM) && (m_ib < N_IN);
      out_open = ((m_ph == P_STREAM) || (m_ph == P_WAIT)) && (m_ob < N_OUT);
      check("busy",        busy,         m_ph != P_IDLE);
      check("ap_start",    ap_start,     m_ph == P_START);
      check("done",        done,         m_done);
      check("block_err",   block_err,    m_berr);
      check("runs_done",   runs_done,    m_runs);
      check("in_r_TVALID", in_r_TVALID,  in_open && src_TVALID);
      check("src_TREADY",  src_TREADY,   in_open && in_r_TREADY);
      check("snk_TVALID",  snk_TVALID,   out_open && out_r_TVALID);
      check("out_r_TREADY", out_r_TREADY, out_open && snk_TREADY);
      check("in_r_TDATA",  in_r_TDATA,   src_TDATA);
      check("snk_TDATA",   snk_TDATA,    out_r_TDATA);
      if (!rst) begin
        in_hs      = in_open && src_TVALID && in_r_TREADY;
        out_hs     = out_open && out_r_TVALID && snk_TREADY;
        was_stream = (m_ph == P_STREAM) || (m_ph == P_WAIT);
        run_end    = 1'b0;
        if (cmd_clear) begin m_done = 1'b0; m_berr = 1'b0; end
        case (m_ph)
          P_IDLE:    if (cmd_start && cmd_runs != 0) begin
                       m_tgt = cmd_runs; m_runs = 0; m_dcap = 1'b0; m_ph = P_START;
                     end
          P_START:   begin
                       if (ap_done) m_dcap = 1'b1;
                       if (ap_ready) begin m_ph = P_STREAM; m_ib = 0; m_ob = 0; end
                     end
          P_STREAM:  begin
                       if (m_ib == N_IN && m_ob == N_OUT) begin
                         if (m_dcap || ap_done) run_end = 1'b1; else m_ph = P_WAIT;
                       end else if (ap_done) m_dcap = 1'b1;
                       if (in_hs) m_ib++;
                       if (out_hs) m_ob++;
                     end
          P_WAIT:    if (m_dcap || ap_done) run_end = 1'b1;
          P_FIN:     begin m_done = 1'b1; m_ph = P_IDLE; end
          P_BLOCKED: if (cmd_clear) m_ph = P_IDLE;
          default:   m_ph = P_IDLE;
        endcase
        if (run_end) begin
          m_runs++; m_dcap = 1'b0;
          m_ph = (m_runs < m_tgt) ? P_START : P_FIN;
        end
`ifdef SEQ_WATCHDOG_EN
        if (was_stream && !in_hs && !out_hs && !ap_done) begin
          m_wd++;
          if (m_wd == TIMEOUT) begin m_ph = P_BLOCKED; m_berr = 1'b1; m_wd = 0; end
        end else m_wd = 0;
`else
        m_wd = was_stream ? m_wd : 0;
`endif
      end
    end
  end

  task automatic start_batch(input int n);
    @(posedge clk); #1;
    cmd_start = 1'b1; cmd_runs = CNT_W'(n);
    @(posedge clk); #1;
    cmd_start = 1'b0;
  endtask

  task automatic pulse_clear();
    @(posedge clk); #1;
    cmd_clear = 1'b1;
    @(posedge clk); #1;
    cmd_clear = 1'b0;
  endtask

  task automatic wait_done(input int max_cycles);
    for (int i = 0; i < max_cycles && !done; i++) @(negedge clk);
    check("done_reached", done, 1'b1);
  endtask

  int base_in, base_out, base_p;

  task automatic mark();
    base_in = src_idx; base_out = snk_cnt; base_p = start_pulses;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", busy, 1'b0);
    check("reset_src_TREADY", src_TREADY, 1'b0);
    rst = 1'b0;

    // Single run, continuous flow
    mark(); src_total = src_idx + 20 - 4;
    start_batch(1);
    wait_done(300);
    check("r1_in_beats", src_idx - base_in, 16);
    check("r1_out_beats", snk_cnt - base_out, 4);
    check("r1_ap_start_pulses", start_pulses - base_p, 1);
    check("r1_runs_done", runs_done, 1);
    pulse_clear();
    @(negedge clk);
    check("clear_done", done, 1'b0);

    // Zero-length batch is ignored
    start_batch(0);
    repeat (3) @(negedge clk);
    check("zero_runs_idle", busy, 1'b0);

    // Three runs with random throttling; a mid-batch start is ignored
    thr = 1'b1; mark(); src_total = src_idx + 48;
    start_batch(3);
    repeat (20) @(posedge clk);
    start_batch(7);
    wait_done(3000);
    check("r3_in_beats", src_idx - base_in, 48);
    check("r3_out_beats", snk_cnt - base_out, 12);
    check("r3_ap_start_pulses", start_pulses - base_p, 3);
    check("r3_runs_done", runs_done, 3);
    thr = 1'b0;
    pulse_clear();

    // Source offers 20 beats: the last 4 wait for the next run
    mark(); src_total = src_idx + 20;
    start_batch(2);
    for (int i = 0; i < 300 && runs_done != 1; i++) @(negedge clk);
    check("hold_runs_done", runs_done, 1);
    check("hold_in_beats", src_idx - base_in, 16);
    check("hold_src_TVALID", src_TVALID, 1'b1);
    check("hold_src_TREADY", src_TREADY, 1'b0);
    repeat (30) @(negedge clk);
    check("hold_second_run_beats", src_idx - base_in, 20);
    src_total = src_idx + 12;
    wait_done(300);
    check("hold_total_in", src_idx - base_in, 32);
    pulse_clear();

    // Early ap_done: sink stalls after 3 beats, run must not finish
    mark(); src_total = src_idx + 16; k_done_at = 3; snk_limit = snk_cnt + 3;
    start_batch(1);
    for (int i = 0; i < 300 && (src_idx - base_in) < 16; i++) @(negedge clk);
    repeat (10) @(negedge clk);
    check("early_busy", busy, 1'b1);
    check("early_not_done", done, 1'b0);
    check("early_out_beats", snk_cnt - base_out, 3);
    snk_limit = 1 << 30;
    wait_done(300);
    check("early_final_out", snk_cnt - base_out, 4);
    k_done_at = 4;
    pulse_clear();

    // Reset mid-run at in_cnt = 7
    mark(); src_total = src_idx + 16;
    start_batch(1);
    for (int i = 0; i < 300 && (src_idx - base_in) < 7; i++) @(negedge clk);
    check("rst_at_beat7", src_idx - base_in, 7);
    #2 rst = 1'b1;
    #1;
    check("arst_busy", busy, 1'b0);
    check("arst_ap_start", ap_start, 1'b0);
    check("arst_src_TREADY", src_TREADY, 1'b0);
    check("arst_in_r_TVALID", in_r_TVALID, 1'b0);
    check("arst_runs_done", runs_done, 0);
    @(posedge clk); @(posedge clk); #4;
    rst = 1'b0;
    mark(); src_total = src_idx + 16;
    start_batch(1);
    wait_done(300);
    check("post_rst_in_beats", src_idx - base_in, 16);
    check("post_rst_out_beats", snk_cnt - base_out, 4);
    check("post_rst_runs_done", runs_done, 1);
    pulse_clear();

`ifdef SEQ_WATCHDOG_EN
    // Kernel stalls completely: watchdog trips, clear recovers
    k_en = 1'b0; mark(); src_total = src_idx + 16;
    start_batch(1);
    for (int i = 0; i < 1300 && !block_err; i++) @(negedge clk);
    check("wd_block_err", block_err, 1'b1);
    check("wd_busy", busy, 1'b1);
    pulse_clear();
    @(negedge clk);
    check("wd_cleared_err", block_err, 1'b0);
    check("wd_cleared_idle", busy, 1'b0);
    k_en = 1'b1;
`endif

    repeat (5) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
